// File: rtl/iter_shifter_pkg.sv
// Shared constants for iter_shifter: flag bit positions, shift-op codes,
// FSM state encodings and a flag-packing helper.
package iter_shifter_pkg;

  localparam int unsigned CNT_W = 6;

  // Flag positions inside the 5-bit XNZVC vector
  localparam int unsigned BITPOS_X = 4;
  localparam int unsigned BITPOS_N = 3;
  localparam int unsigned BITPOS_Z = 2;
  localparam int unsigned BITPOS_V = 1;
  localparam int unsigned BITPOS_C = 0;

  // Shift families
  localparam logic [1:0] SHOP_ASX  = 2'd0;
  localparam logic [1:0] SHOP_LSX  = 2'd1;
  localparam logic [1:0] SHOP_ROXX = 2'd2;
  localparam logic [1:0] SHOP_ROX  = 2'd3;

  // Flag-change masks
  localparam logic [4:0] CHG_ALL  = 5'b11111;
  localparam logic [4:0] CHG_NO_X = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [4:0] pack_flags(input logic x, input logic n,
                                            input logic z, input logic v,
                                            input logic c);
    logic [4:0] f;
    f           = '0;
    f[BITPOS_X] = x;
    f[BITPOS_N] = n;
    f[BITPOS_Z] = z;
    f[BITPOS_V] = v;
    f[BITPOS_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/iter_shifter_shift_step.sv
// One-bit shift/rotate step for all four 68k shift families.
// Ports: i_val/i_x/i_op/i_dir in; o_val (shifted value), o_bit (bit shifted
// out), o_msb_chg (MSB differs between input and output) out.
module iter_shifter_shift_step
  import iter_shifter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_val,
  input  logic         i_x,
  input  logic [1:0]   i_op,
  input  logic         i_dir,
  output logic [N-1:0] o_val,
  output logic         o_bit,
  output logic         o_msb_chg
);

  logic w_fill;

  // Select the bit entering the vacated end and form the shifted value
  always_comb begin
    w_fill = 1'b0;
    o_bit  = 1'b0;
    o_val  = i_val;
    if (i_dir) begin
      o_bit = i_val[N-1];
      case (i_op)
        SHOP_ROXX: w_fill = i_x;
        SHOP_ROX:  w_fill = i_val[N-1];
        default:   w_fill = 1'b0;
      endcase
      o_val = {i_val[N-2:0], w_fill};
    end else begin
      o_bit = i_val[0];
      case (i_op)
        SHOP_ASX:  w_fill = i_val[N-1];
        SHOP_ROXX: w_fill = i_x;
        SHOP_ROX:  w_fill = i_val[0];
        default:   w_fill = 1'b0;
      endcase
      o_val = {w_fill, i_val[N-1:1]};
    end
  end

  assign o_msb_chg = o_val[N-1] ^ i_val[N-1];

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit (ASx, LSx, ROXx, ROx) returning result,
// XNZVC flags and a flag-change mask.
// Ports: in_CLK, in_RESET (async, active low), in_START, in_OP, in_DIR,
// in_A, in_CNT, in_X in; out_BUSY, out_DONE, out_RES, out_XNZVC,
// out_XNZVC_chg out (all registered).
// Build option: ITER_SHIFTER_BARREL_EN selects a single-cycle barrel
// datapath instead of STEP bit positions per clock.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned STEP = 1
) (
  input  logic             in_CLK,
  input  logic             in_RESET,
  input  logic             in_START,
  input  logic [1:0]       in_OP,
  input  logic             in_DIR,
  input  logic [N-1:0]     in_A,
  input  logic [CNT_W-1:0] in_CNT,
  input  logic             in_X,
  output logic             out_BUSY,
  output logic             out_DONE,
  output logic [N-1:0]     out_RES,
  output logic [4:0]       out_XNZVC,
  output logic [4:0]       out_XNZVC_chg
);

  if (!((N == 8) || (N == 16) || (N == 32)) ||
      !((STEP == 1) || (STEP == 2) || (STEP == 4) || (STEP == 8))) begin : g_bad_param
    $error("iter_shifter: illegal N or STEP");
  end

  state_e r_state;

`ifdef ITER_SHIFTER_BARREL_EN
  localparam int unsigned STAGES = 63;

  logic [STAGES:0][N-1:0] w_val;
  logic [STAGES:0]        w_x;
  logic [STAGES:0]        w_c;
  logic [STAGES:0]        w_v;
  logic                   w_is_asl;
  logic                   w_zero;
  logic                   w_x_fin;
  logic                   w_c_fin;

  assign w_is_asl = (in_OP == SHOP_ASX) && in_DIR;
  assign w_zero   = (in_CNT == '0);
  assign w_val[0] = in_A;
  assign w_x[0]   = in_X;
  assign w_c[0]   = 1'b0;
  assign w_v[0]   = 1'b0;

  // 63 chained one-bit steps; stage g is active while g < CNT
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [N-1:0] w_nv;
    logic         w_bit;
    logic         w_msb;
    logic         w_act;
    assign w_act = (6'(g) < in_CNT);
    iter_shifter_shift_step #(.N(N)) u_step (
      .i_val     (w_val[g]),
      .i_x       (w_x[g]),
      .i_op      (in_OP),
      .i_dir     (in_DIR),
      .o_val     (w_nv),
      .o_bit     (w_bit),
      .o_msb_chg (w_msb)
    );
    assign w_val[g+1] = w_act ? w_nv : w_val[g];
    assign w_x[g+1]   = (w_act && (in_OP == SHOP_ROXX)) ? w_bit : w_x[g];
    assign w_c[g+1]   = w_act ? w_bit : w_c[g];
    assign w_v[g+1]   = w_v[g] | (w_act & w_is_asl & w_msb);
  end

  // X follows C unless ROx or a zero count; ROXx with zero count copies X to C
  assign w_x_fin = (w_zero || (in_OP == SHOP_ROX)) ? w_x[STAGES] : w_c[STAGES];
  assign w_c_fin = (w_zero && (in_OP == SHOP_ROXX)) ? in_X : w_c[STAGES];

  always_ff @(posedge in_CLK or negedge in_RESET) begin
    if (!in_RESET) begin
      r_state       <= ST_IDLE;
      out_BUSY      <= 1'b0;
      out_DONE      <= 1'b0;
      out_RES       <= '0;
      out_XNZVC     <= '0;
      out_XNZVC_chg <= '0;
    end else begin
      out_BUSY <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          out_DONE <= 1'b0;
          r_state  <= ST_IDLE;
          if (in_START) begin
            r_state       <= ST_DONE;
            out_DONE      <= 1'b1;
            out_RES       <= w_val[STAGES];
            out_XNZVC     <= pack_flags(w_x_fin, w_val[STAGES][N-1],
                                        (w_val[STAGES] == '0), w_v[STAGES], w_c_fin);
            out_XNZVC_chg <= (w_zero || (in_OP == SHOP_ROX)) ? CHG_NO_X : CHG_ALL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  logic [N-1:0]      r_val;
  logic              r_x;
  logic              r_c;
  logic              r_v;
  logic [1:0]        r_op;
  logic              r_dir;
  logic [CNT_W-1:0]  r_rem;

  logic [STEP:0][N-1:0] w_val;
  logic [STEP:0]        w_x;
  logic [STEP:0]        w_c;
  logic [STEP:0]        w_v;
  logic                 w_is_asl;
  logic [CNT_W-1:0]     w_rem_next;
  logic                 w_x_fin;

  assign w_is_asl   = (r_op == SHOP_ASX) && r_dir;
  assign w_rem_next = (r_rem > CNT_W'(STEP)) ? (r_rem - CNT_W'(STEP)) : '0;
  assign w_val[0]   = r_val;
  assign w_x[0]     = r_x;
  assign w_c[0]     = r_c;
  assign w_v[0]     = r_v;

  // STEP chained one-bit steps per clock; stage g runs only while g < remaining
  for (genvar g = 0; g < STEP; g++) begin : g_stage
    logic [N-1:0] w_nv;
    logic         w_bit;
    logic         w_msb;
    logic         w_act;
    assign w_act = (CNT_W'(g) < r_rem);
    iter_shifter_shift_step #(.N(N)) u_step (
      .i_val     (w_val[g]),
      .i_x       (w_x[g]),
      .i_op      (r_op),
      .i_dir     (r_dir),
      .o_val     (w_nv),
      .o_bit     (w_bit),
      .o_msb_chg (w_msb)
    );
    assign w_val[g+1] = w_act ? w_nv : w_val[g];
    assign w_x[g+1]   = (w_act && (r_op == SHOP_ROXX)) ? w_bit : w_x[g];
    assign w_c[g+1]   = w_act ? w_bit : w_c[g];
    assign w_v[g+1]   = w_v[g] | (w_act & w_is_asl & w_msb);
  end

  // ROx keeps the latched X; every other family copies C into X
  assign w_x_fin = (r_op == SHOP_ROX) ? w_x[STEP] : w_c[STEP];

  always_ff @(posedge in_CLK or negedge in_RESET) begin
    if (!in_RESET) begin
      r_state       <= ST_IDLE;
      r_val         <= '0;
      r_x           <= 1'b0;
      r_c           <= 1'b0;
      r_v           <= 1'b0;
      r_op          <= '0;
      r_dir         <= 1'b0;
      r_rem         <= '0;
      out_BUSY      <= 1'b0;
      out_DONE      <= 1'b0;
      out_RES       <= '0;
      out_XNZVC     <= '0;
      out_XNZVC_chg <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          out_DONE <= 1'b0;
          r_state  <= ST_IDLE;
          if (in_START) begin
            r_val <= in_A;
            r_x   <= in_X;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_op  <= in_OP;
            r_dir <= in_DIR;
            r_rem <= in_CNT;
            if (in_CNT == '0) begin
              // Zero count: pass A through, X untouched, C mirrors X only for ROXx
              r_state       <= ST_DONE;
              out_DONE      <= 1'b1;
              out_RES       <= in_A;
              out_XNZVC     <= pack_flags(in_X, in_A[N-1], (in_A == '0), 1'b0,
                                          (in_OP == SHOP_ROXX) ? in_X : 1'b0);
              out_XNZVC_chg <= CHG_NO_X;
            end else begin
              r_state  <= ST_SHIFT;
              out_BUSY <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_val <= w_val[STEP];
          r_x   <= w_x[STEP];
          r_c   <= w_c[STEP];
          r_v   <= w_v[STEP];
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state       <= ST_DONE;
            out_BUSY      <= 1'b0;
            out_DONE      <= 1'b1;
            out_RES       <= w_val[STEP];
            out_XNZVC     <= pack_flags(w_x_fin, w_val[STEP][N-1],
                                        (w_val[STEP] == '0), w_v[STEP], w_c[STEP]);
            out_XNZVC_chg <= (r_op == SHOP_ROX) ? CHG_NO_X : CHG_ALL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter (N=32, STEP=1).
module tb_iter_shifter;

  localparam int unsigned N    = 32;
  localparam int unsigned STEP = 1;
`ifdef ITER_SHIFTER_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic          in_CLK;
  logic          in_RESET;
  logic          in_START;
  logic [1:0]    in_OP;
  logic          in_DIR;
  logic [N-1:0]  in_A;
  logic [5:0]    in_CNT;
  logic          in_X;
  logic          out_BUSY;
  logic          out_DONE;
  logic [N-1:0]  out_RES;
  logic [4:0]    out_XNZVC;
  logic [4:0]    out_XNZVC_chg;

  iter_shifter #(.N(N), .STEP(STEP)) dut (
    .in_CLK        (in_CLK),
    .in_RESET      (in_RESET),
    .in_START      (in_START),
    .in_OP         (in_OP),
    .in_DIR        (in_DIR),
    .in_A          (in_A),
    .in_CNT        (in_CNT),
    .in_X          (in_X),
    .out_BUSY      (out_BUSY),
    .out_DONE      (out_DONE),
    .out_RES       (out_RES),
    .out_XNZVC     (out_XNZVC),
    .out_XNZVC_chg (out_XNZVC_chg)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  fl;
    logic [4:0]  chg;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial begin
    in_CLK = 1'b0;
    forever #5 in_CLK = ~in_CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge in_CLK);
    #1;
    cyc++;
  endtask

  function automatic int exp_cycles(input logic [5:0] cnt);
    if (BARREL || cnt == 6'd0) return 1;
    return (int'(cnt) + int'(STEP) - 1) / int'(STEP) + 1;
  endfunction

  // Reference model: closed-form shifts on widened operands
  function automatic exp_t model(input logic [1:0] op, input logic dir,
                                 input logic [31:0] a, input logic [5:0] cnt,
                                 input logic x);
    exp_t        e;
    logic [63:0] t;
    logic [32:0] w;
    logic        c, v, b;
    int          r;
    c = 1'b0;
    v = 1'b0;
    e.res = a;
    if (cnt != 6'd0) begin
      case (op)
        2'd0, 2'd1: begin
          if (dir) begin
            t = {32'd0, a} << cnt;
            e.res = t[31:0];
            c = t[32];
            if (op == 2'd0) begin
              for (int i = 1; i <= int'(cnt); i++) begin
                if (i <= 31) b = a[31-i];
                else b = 1'b0;
                if (b != a[31]) v = 1'b1;
              end
            end
          end else if (op == 2'd1) begin
            t = {a, 32'd0} >> cnt;
            e.res = t[63:32];
            c = t[31];
          end else begin
            t = {a, 32'd0};
            t = 64'($signed(t) >>> cnt);
            e.res = t[63:32];
            c = t[31];
          end
        end
        2'd2: begin
          w = {x, a};
          r = int'(cnt) % 33;
          if (dir) w = (w << r) | (w >> (33 - r));
          else     w = (w >> r) | (w << (33 - r));
          e.res = w[31:0];
          c = w[32];
        end
        default: begin
          r = int'(cnt) % 32;
          if (dir) begin
            e.res = (a << r) | (a >> (32 - r));
            c = e.res[0];
          end else begin
            e.res = (a >> r) | (a << (32 - r));
            c = e.res[31];
          end
        end
      endcase
    end else if (op == 2'd2) begin
      c = x;
    end
    e.fl  = {((op == 2'd3) || (cnt == 6'd0)) ? x : c, e.res[31], (e.res == 32'd0), v, c};
    e.chg = ((op == 2'd3) || (cnt == 6'd0)) ? 5'b01111 : 5'b11111;
    e.cyc = exp_cycles(cnt);
    e.tag = "";
    return e;
  endfunction

  task automatic drive_start(input logic [1:0] op, input logic dir, input logic [31:0] a,
                             input logic [5:0] cnt, input logic x);
    in_START = 1'b1;
    in_OP    = op;
    in_DIR   = dir;
    in_A     = a;
    in_CNT   = cnt;
    in_X     = x;
    @(posedge in_CLK);
    #1;
    in_START = 1'b0;
    cyc = 0;
  endtask

  task automatic start_op(input string tag, input logic [1:0] op, input logic dir,
                          input logic [31:0] a, input logic [5:0] cnt, input logic x,
                          input logic [31:0] res, input logic [4:0] fl, input logic [4:0] chg);
    exp_t e;
    e.tag = tag;
    e.res = res;
    e.fl  = fl;
    e.chg = chg;
    e.cyc = exp_cycles(cnt);
    sb.push_back(e);
    drive_start(op, dir, a, cnt, x);
  endtask

  task automatic start_model(input string tag, input logic [1:0] op, input logic dir,
                             input logic [31:0] a, input logic [5:0] cnt, input logic x);
    exp_t e;
    e = model(op, dir, a, cnt, x);
    e.tag = tag;
    sb.push_back(e);
    drive_start(op, dir, a, cnt, x);
  endtask

  task automatic wait_done();
    exp_t e;
    for (int i = 0; i < 200 && !out_DONE; i++) tick();
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_done"}, 32'(out_DONE), 32'd1);
    check({e.tag, "_cyc"},  32'(cyc + 1), 32'(e.cyc));
    check({e.tag, "_res"},  out_RES, e.res);
    check({e.tag, "_flg"},  32'(out_XNZVC), 32'(e.fl));
    check({e.tag, "_chg"},  32'(out_XNZVC_chg), 32'(e.chg));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_res"},  out_RES, 32'd0);
    check({tag, "_flg"},  32'(out_XNZVC), 32'd0);
    check({tag, "_chg"},  32'(out_XNZVC_chg), 32'd0);
    check({tag, "_busy"}, 32'(out_BUSY), 32'd0);
    check({tag, "_done"}, 32'(out_DONE), 32'd0);
  endtask

  initial begin
    exp_t       e;
    logic [1:0] op;
    logic       dir;
    logic [5:0] cnt;
    in_RESET = 1'b0;
    in_START = 1'b0;
    in_OP    = '0;
    in_DIR   = 1'b0;
    in_A     = '0;
    in_CNT   = '0;
    in_X     = 1'b0;
    #12;
    check_cleared("reset");
    in_RESET = 1'b1;
    tick();

    start_op("roxl1", 2'd2, 1'b1, 32'h8000_0001, 6'd1, 1'b0, 32'h0000_0002, 5'b10001, 5'b11111);
    wait_done();
    start_op("asl_v", 2'd0, 1'b1, 32'h4000_0000, 6'd1, 1'b1, 32'h8000_0000, 5'b01010, 5'b11111);
    wait_done();
    start_op("asl3", 2'd0, 1'b1, 32'h0000_0001, 6'd3, 1'b1, 32'h0000_0008, 5'b00000, 5'b11111);
    wait_done();
    start_op("asr40", 2'd0, 1'b0, 32'h8000_0000, 6'd40, 1'b0, 32'hFFFF_FFFF, 5'b11001, 5'b11111);
    wait_done();
    start_op("lsr0", 2'd1, 1'b0, 32'h0000_0000, 6'd0, 1'b1, 32'h0000_0000, 5'b10100, 5'b01111);
    wait_done();
    start_op("roxr0", 2'd2, 1'b0, 32'h0000_0005, 6'd0, 1'b1, 32'h0000_0005, 5'b10001, 5'b01111);
    wait_done();

    // Long LSL with a stray start while shifting, then a back-to-back start
    start_op("lsl20", 2'd1, 1'b1, 32'h0000_0ABC, 6'd20, 1'b1, 32'hABC0_0000, 5'b01000, 5'b11111);
    if (!BARREL) begin
      tick();
      tick();
      in_START = 1'b1;
      in_OP    = 2'd1;
      in_DIR   = 1'b0;
      in_A     = 32'hFFFF_FFFF;
      in_CNT   = 6'd1;
      tick();
      in_START = 1'b0;
    end
    wait_done();
    start_op("b2b_lsr", 2'd1, 1'b0, 32'hF000_0000, 6'd4, 1'b1, 32'h0F00_0000, 5'b00000, 5'b11111);
    check("b2b_hold_res", out_RES, 32'hABC0_0000);
    check("b2b_busy", 32'(out_BUSY), BARREL ? 32'd0 : 32'd1);
    wait_done();

    for (int i = 0; i < 12; i++) begin
      op  = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      case (i)
        0:       cnt = 6'd0;
        1:       cnt = 6'd32;
        2:       cnt = 6'd33;
        3:       cnt = 6'd63;
        default: cnt = 6'($urandom_range(1, 63));
      endcase
      start_model($sformatf("rnd%0d_op%0d_d%0d_c%0d", i, op, dir, cnt),
                  op, dir, $urandom, cnt, 1'($urandom_range(0, 1)));
      wait_done();
    end

    // Reset in the middle of a ROL: everything clears asynchronously
    start_model("rol_rst", 2'd3, 1'b1, 32'h1234_5678, 6'd20, 1'b0);
    tick();
    tick();
    tick();
    tick();
    #2;
    in_RESET = 1'b0;
    #1;
    check_cleared("midrst");
    e = sb.pop_front();
    @(posedge in_CLK);
    #4;
    in_RESET = 1'b1;
    tick();
    check("post_rst_busy", 32'(out_BUSY), 32'd0);
    check("post_rst_done", 32'(out_DONE), 32'd0);
    start_op("rol4", 2'd3, 1'b1, 32'h8000_000F, 6'd4, 1'b1, 32'h0000_00F8, 5'b10000, 5'b01111);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Parametrised multi-cycle shift/rotate unit for the VCPU execution stage, generalising the ALU's single-cycle ROXx path to all four 68k shift families (ASx, LSx, ROx, ROXx), both directions, counts 0–63 and configurable width. Operands are latched on a start handshake and shifted `STEP` bit positions per clock. On completion the unit returns the result and the XNZVC flags with a per-flag change mask. It sits beside `ALU` and is sequenced by the VCPU control logic.

## Interface
- `N`, 32: operand width. Legal values: 8, 16, 32.
- `STEP`, 1: bit positions shifted per clock. Legal values: 1, 2, 4, 8.

- `in_CLK`  in  1  clock, rising edge.
- `in_RESET`  in  1  asynchronous, active-low reset.
- `in_START`  in  1  start request. Sampled only when the unit is not BUSY.
- `in_OP`  in  2  operation: 0 ASx, 1 LSx, 2 ROXx, 3 ROx.
- `in_DIR`  in  1  direction: 0 right, 1 left.
- `in_A`  in  N  operand.
- `in_CNT`  in  6  shift count, 0–63. The caller has already reduced it modulo 64.
- `in_X`  in  1  current X flag.
- `out_BUSY`  out  1  high in SHIFT.
- `out_DONE`  out  1  one-cycle completion pulse.
- `out_RES`  out  N  result. Held after DONE until the next start.
- `out_XNZVC`  out  5  flags, indexed by `bitpos_X/N/Z/V/C`.
- `out_XNZVC_chg`  out  5  mask of flags written by this operation.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset forces IDLE.
- Reset value of every output is 0.
- IDLE or DONE, with `in_START`=1:
  - latch `in_OP`, `in_DIR`, `in_A`, `in_CNT` and `in_X` into the working regs;
  - go to SHIFT if CNT≠0, otherwise go to DONE.
- SHIFT:
  - each clock, shift by k = min(STEP, remaining) and decrement remaining by k;
  - go to DONE when remaining reaches 0.
- DONE: `out_DONE`=1 for exactly one cycle, then IDLE, unless a new start is accepted in that same cycle.
- `in_START` in SHIFT is ignored; it is not queued.
- Shift semantics, one bit per step:
  - ASL/LSL shift in 0. ASR shifts in the MSB. LSR shifts in 0.
  - ROx feeds the bit shifted out back into the vacated end.
  - ROXx is an (N+1)-bit rotate through the working X.
- Flags at DONE:
  - N = RES[N-1]; Z = (RES==0).
  - C = last bit shifted out.
  - X = C for ASx, LSx and ROXx when CNT≠0. X is unchanged for ROx.
  - V = 1 only for ASL when the MSB changed at any step (sticky across steps); V = 0 otherwise.
- CNT=0 handling:
  - RES = A; V = 0; X is unchanged.
  - C = latched X for ROXx, otherwise C = 0.
- `out_XNZVC_chg` = 5'b11111, except that the X bit is 0 for ROx or CNT=0.
- CNT ≥ N for ASx/LSx is not special-cased; iteration saturates the result naturally:
  - LSx gives 0;
  - ASR gives all sign bits;
  - C = last bit out, which is 0 once CNT > N for LSx and ASL.

## Timing
- The start-accept edge is cycle 0. DONE is asserted in cycle ceil(CNT/STEP)+1.
  - CNT=0 gives DONE in cycle 1.
  - CNT=63 with STEP=1 gives DONE in cycle 64.
- `out_RES` and `out_XNZVC` are registered and are valid from the DONE cycle onward.
- Back-to-back: a start accepted in the DONE cycle begins the next operation with no idle bubble. The previous result stays on the outputs until the new DONE.
- Reset mid-operation: all outputs clear asynchronously, the operation is dropped, and the FSM is in IDLE on the first edge after release.

## Configuration
- `ITER_SHIFTER_BARREL_EN` defined:
  - SHIFT is replaced by a single combinational barrel stage;
  - every operation reaches DONE in cycle 1, whatever CNT is;
  - results and flags are bit-identical to the iterative path;
  - `out_BUSY` stays 0.
- Undefined: iterative datapath as described, with STEP stages per clock.

## Structure
- The shared header `vcpu.vh` holds:
  - `bitpos_X/N/Z/V/C`;
  - new op constants `shop_ASx`, `shop_LSx`, `shop_ROXx`, `shop_ROx`;
  - the FSM state encodings.
- Sub-module `shift_step`: combinational one-bit step. Inputs are value, X, op and dir. Outputs are the new value, the bit shifted out, and an MSB-changed flag. It is chained STEP times in SHIFT and 63 times (gated by count) in the barrel variant.

## Test plan
Bench configuration: N=32, STEP=1, unless stated otherwise.
- ROXL, A=0x80000001, X=0, CNT=1 -> RES=0x00000002, X=C=1, N=Z=V=0, chg=11111, DONE in cycle 2.
- ASL, A=0x40000000, CNT=1 -> RES=0x80000000, N=1, V=1, C=X=0. Then ASL, A=0x00000001, CNT=3 -> RES=0x8, V=0.
- ASR, A=0x80000000, CNT=40 -> RES=0xFFFFFFFF, C=X=1, N=1, V=0. DONE in cycle 41 with STEP=1, in cycle 6 with STEP=8, in cycle 1 with `ITER_SHIFTER_BARREL_EN`.
- CNT=0 cases:
  - LSR, A=0, X=1 -> RES=0, Z=1, C=0, chg=01111, DONE in cycle 1;
  - ROXR, A=0x5, X=1 -> C=1, RES=0x5.
- LSL, CNT=20:
  - pulse `in_START` again in cycle 3 -> ignored, DONE in cycle 21;
  - new start in the DONE cycle -> accepted.
- ROL, CNT=20, `in_RESET` low in cycle 5 -> all outputs 0 immediately, BUSY=0. After release, a fresh ROL, A=0x8000000F, CNT=4 -> RES=0x000000F8, C=0, X unchanged (chg=01111).
